// File: rtl/dmi_tlul_pkg.sv
// Shared types, constants and integrity helpers for the DMI to TL-UL bridge.
package dmi_tlul_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReqA  = 3'd1,
        StWaitD = 3'd2,
        StResp  = 3'd3,
        StDrain = 3'd4
    } dmi_tlul_state_e;

    // DTM response codes (Busy is reserved, never produced by the bridge).
    localparam logic [1:0] DtmSuccess = 2'd0;
    localparam logic [1:0] DtmErr     = 2'd2;
    localparam logic [1:0] DtmBusy    = 2'd3;

    // DTM request ops; op 3 is reserved and treated as a NOP.
    localparam logic [1:0] DtmNop   = 2'd0;
    localparam logic [1:0] DtmRead  = 2'd1;
    localparam logic [1:0] DtmWrite = 2'd2;

    localparam logic [2:0] TlPutFullData   = 3'd0;
    localparam logic [2:0] TlGet           = 3'd4;
    localparam logic [2:0] TlAccessAck     = 3'd0;
    localparam logic [2:0] TlAccessAckData = 3'd1;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Folds 64 bits into a 7-bit check code; any single-bit flip changes the code.
    function automatic logic [6:0] intg_fold(input logic [63:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c[i % 7] = c[i % 7] ^ d[i];
        end
        return c;
    endfunction

    function automatic logic [6:0] cmd_intg_calc(input logic [2:0] opcode, input logic [3:0] mask,
                                                 input logic [31:0] address);
        return intg_fold({25'h0, opcode, mask, address});
    endfunction

    function automatic logic [6:0] data_intg_calc(input logic [31:0] data);
        return intg_fold({32'h0, data});
    endfunction

    function automatic logic [6:0] rsp_intg_calc(input logic [2:0] opcode, input logic [1:0] size,
                                                 input logic error);
        return intg_fold({58'h0, opcode, size, error});
    endfunction

endpackage

// File: rtl/prim_flop.sv
// Plain asynchronous-reset register with a configurable reset value.
module prim_flop #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    // Storage element
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_o <= ResetValue;
        else         q_o <= d_i;
    end

endmodule

// File: rtl/tlul_cmd_intg_gen.sv
// Fills in a_user command and data integrity for an outgoing TL-UL request.
module tlul_cmd_intg_gen
    import dmi_tlul_pkg::*;
(
    input  tl_h2d_t tl_i,
    output tl_h2d_t tl_o
);

    // Pass the request through, overwriting only the integrity fields
    always_comb begin
        tl_o                  = tl_i;
        tl_o.a_user.cmd_intg  = cmd_intg_calc(tl_i.a_opcode, tl_i.a_mask, tl_i.a_address);
        tl_o.a_user.data_intg = data_intg_calc(tl_i.a_data);
    end

endmodule

// File: rtl/tlul_rsp_intg_chk.sv
// Checks d_user response and data integrity of an incoming TL-UL response.
module tlul_rsp_intg_chk
    import dmi_tlul_pkg::*;
(
    input  tl_d2h_t tl_i,
    output logic    err_o
);

    logic unused_fields;
    assign unused_fields = ^{tl_i.d_valid, tl_i.d_param, tl_i.d_source, tl_i.d_sink, tl_i.a_ready};

    // Flag any mismatch between the carried and recomputed codes
    always_comb begin
        err_o = (tl_i.d_user.rsp_intg != rsp_intg_calc(tl_i.d_opcode, tl_i.d_size, tl_i.d_error)) ||
                (tl_i.d_user.data_intg != data_intg_calc(tl_i.d_data));
    end

endmodule

// File: rtl/dmi_tlul_bridge.sv
// Turns DMI requests into single-beat TL-UL transactions and returns DMI responses.
module dmi_tlul_bridge
    import dmi_tlul_pkg::*;
#(
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  dmi_req_t  dmi_req_i,
    input  logic      dmi_req_valid_i,
    output logic      dmi_req_ready_o,
    output dmi_resp_t dmi_resp_o,
    output logic      dmi_resp_valid_o,
    input  logic      dmi_resp_ready_i,
    output tl_h2d_t   tl_o,
    input  tl_d2h_t   tl_i,
    output logic      intg_err_o
);

    localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    // Last counter value of WaitD; the abort happens at the end of that cycle.
    localparam logic [CntW-1:0] CntLast = (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

    dmi_tlul_state_e state_q, state_d;
    logic [2:0]      state_raw;
    logic            is_write_q, is_write_d;
    logic [6:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    dmi_resp_t       resp_q, resp_d;
    logic            drain_q, drain_d;
    logic            intg_err_q, intg_err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_intg_err;
    tl_h2d_t         tl_pre;

    prim_flop #(
        .Width      (3),
        .ResetValue (3'(StIdle))
    ) u_state_flop (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (3'(state_d)),
        .q_o   (state_raw)
    );
    assign state_q = dmi_tlul_state_e'(state_raw);

    tlul_rsp_intg_chk u_rsp_chk (
        .tl_i (tl_i),
        .err_o(rsp_intg_err)
    );

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            drain_q    <= 1'b0;
            intg_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            drain_q    <= drain_d;
            intg_err_q <= intg_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        drain_d    = drain_q;
        intg_err_d = intg_err_q;
        cnt_d      = '0;
        unique case (state_q)
            StIdle: begin
                if (dmi_req_valid_i) begin
                    addr_d     = dmi_req_i.addr;
                    is_write_d = (dmi_req_i.op == DtmWrite);
                    wdata_d    = (dmi_req_i.op == DtmWrite) ? dmi_req_i.data : '0;
                    if (dmi_req_i.op == DtmRead || dmi_req_i.op == DtmWrite) begin
                        state_d = StReqA;
                    end else begin
                        resp_d  = '{data: '0, resp: DtmSuccess};
                        state_d = StResp;
                    end
                end
            end
            StReqA: begin
                if (tl_i.a_ready) state_d = StWaitD;
            end
            StWaitD: begin
                // A beat in the final counted cycle still wins over the abort.
                if (tl_i.d_valid) begin
                    resp_d.data = is_write_q ? '0 : tl_i.d_data;
                    resp_d.resp = (tl_i.d_error || rsp_intg_err) ? DtmErr : DtmSuccess;
                    intg_err_d  = intg_err_q | rsp_intg_err;
                    state_d     = StResp;
                end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
                    resp_d  = '{data: '0, resp: DtmErr};
                    drain_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (dmi_resp_ready_i) state_d = drain_q ? StDrain : StIdle;
            end
            StDrain: begin
                // The late beat is discarded but its integrity still counts.
                if (tl_i.d_valid) begin
                    intg_err_d = intg_err_q | rsp_intg_err;
                    drain_d    = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // TL-UL request fields, all from registered state
    always_comb begin
        tl_pre           = '0;
        tl_pre.a_valid   = (state_q == StReqA);
        tl_pre.a_opcode  = is_write_q ? TlPutFullData : TlGet;
        tl_pre.a_size    = 2'd2;
        tl_pre.a_mask    = 4'hF;
        tl_pre.a_address = BaseAddr | {23'h0, addr_q, 2'b00};
        tl_pre.a_data    = wdata_q;
        tl_pre.d_ready   = (state_q == StWaitD) || (state_q == StDrain);
    end

    tlul_cmd_intg_gen u_cmd_gen (
        .tl_i(tl_pre),
        .tl_o(tl_o)
    );

    assign dmi_req_ready_o  = (state_q == StIdle);
    assign dmi_resp_valid_o = (state_q == StResp);
    assign dmi_resp_o       = resp_q;
    assign intg_err_o       = intg_err_q;

endmodule

// File: tb/tb_dmi_tlul_bridge.sv
// Randomised bench for dmi_tlul_bridge with a memory-backed TL-UL device and a DMI-level model.
module tb_dmi_tlul_bridge;
    import dmi_tlul_pkg::*;

    localparam logic [31:0] BaseAddr      = 32'h4000_0000;
    localparam int unsigned TimeoutCycles = 16;

    logic      clk;
    logic      rst_n;
    dmi_req_t  dmi_req;
    logic      dmi_req_valid;
    logic      dmi_req_ready;
    dmi_resp_t dmi_resp;
    logic      dmi_resp_valid;
    logic      dmi_resp_ready;
    tl_h2d_t   tl_h2d;
    tl_d2h_t   tl_d2h;
    logic      intg_err;

    dmi_tlul_bridge #(
        .BaseAddr     (BaseAddr),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dmi_req_i       (dmi_req),
        .dmi_req_valid_i (dmi_req_valid),
        .dmi_req_ready_o (dmi_req_ready),
        .dmi_resp_o      (dmi_resp),
        .dmi_resp_valid_o(dmi_resp_valid),
        .dmi_resp_ready_i(dmi_resp_ready),
        .tl_o            (tl_h2d),
        .tl_i            (tl_d2h),
        .intg_err_o      (intg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Device model state and knobs
    logic [31:0] dev_mem [128];
    logic [31:0] ref_mem [128];
    int          dev_delay = 0;
    bit          dev_err = 0;
    bit          dev_corrupt = 0;
    bit          dev_rand_ready = 0;
    int          a_count = 0;
    int          d_hs_cyc = 0;
    logic [31:0] last_a_addr, last_a_data;
    logic [2:0]  last_a_op;
    logic [3:0]  last_a_mask;
    logic [1:0]  last_a_size;
    logic [6:0]  last_a_cmd, last_a_dintg;

    // TL-UL device: acts on negedges, handshakes complete at the following posedge
    initial begin
        bit      a_pend, d_pend, busy;
        int      resp_at;
        tl_d2h_t nxt;
        logic [6:0] idx;
        a_pend = 0; d_pend = 0; busy = 0; resp_at = 0; nxt = '0;
        tl_d2h = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_pend = 0; d_pend = 0; busy = 0; tl_d2h = '0;
                continue;
            end
            if (d_pend) begin
                tl_d2h.d_valid = 1'b0;
                busy = 0;
                d_pend = 0;
            end
            if (a_pend) begin
                a_pend  = 0;
                busy    = 1;
                resp_at = cyc + dev_delay;
                idx     = last_a_addr[8:2];
                nxt     = '0;
                nxt.d_size  = 2'd2;
                nxt.d_error = dev_err;
                if (last_a_op == TlPutFullData) begin
                    nxt.d_opcode = TlAccessAck;
                    if (!dev_err) dev_mem[idx] = last_a_data;
                end else begin
                    nxt.d_opcode = TlAccessAckData;
                    nxt.d_data   = dev_err ? 32'hBAD0_0000 : dev_mem[idx];
                end
                nxt.d_user.rsp_intg  = rsp_intg_calc(nxt.d_opcode, nxt.d_size, nxt.d_error) ^
                                       (dev_corrupt ? 7'h01 : 7'h00);
                nxt.d_user.data_intg = data_intg_calc(nxt.d_data);
            end
            if (busy && !tl_d2h.d_valid && cyc >= resp_at) begin
                tl_d2h = nxt;
                tl_d2h.d_valid = 1'b1;
            end
            tl_d2h.a_ready = dev_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tl_h2d.a_valid && tl_d2h.a_ready) begin
                a_pend       = 1;
                a_count++;
                last_a_addr  = tl_h2d.a_address;
                last_a_data  = tl_h2d.a_data;
                last_a_op    = tl_h2d.a_opcode;
                last_a_mask  = tl_h2d.a_mask;
                last_a_size  = tl_h2d.a_size;
                last_a_cmd   = tl_h2d.a_user.cmd_intg;
                last_a_dintg = tl_h2d.a_user.data_intg;
            end
            if (tl_d2h.d_valid && tl_h2d.d_ready) begin
                d_pend   = 1;
                d_hs_cyc = cyc;
            end
        end
    end

    // One DMI transaction; lat counts cycles from the request handshake to response valid
    task automatic dmi_xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                            input int hold, output dmi_resp_t r, output int lat);
        int n;
        bit stable_ok;
        n = 0;
        dmi_req = '{addr: addr, op: op, data: data};
        dmi_req_valid = 1'b1;
        while (!dmi_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("req_ready_wait", 64'(dmi_req_ready), 64'd1);
        @(negedge clk);
        dmi_req_valid = 1'b0;
        lat = 1;
        while (!dmi_resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 300) check_eq("resp_valid_wait", 64'(dmi_resp_valid), 64'd1);
        r = dmi_resp;
        stable_ok = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (dmi_resp !== r || !dmi_resp_valid || dmi_req_ready || tl_h2d.a_valid) stable_ok = 0;
        end
        if (hold > 0) check_eq("resp_hold_stable", 64'(stable_ok), 64'd1);
        dmi_resp_ready = 1'b1;
        @(negedge clk);
        dmi_resp_ready = 1'b0;
    endtask

    // Runs one transaction and compares it with the DMI-level model
    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [6:0] addr,
                                 input logic [31:0] data, input int hold, input bit err,
                                 input bit corrupt, input bit tmo, input int exp_lat);
        dmi_resp_t   r;
        int          lat;
        int          a_before;
        bit          is_tl;
        logic [31:0] exp_data;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_addr;
        logic [2:0]  exp_op;
        logic [31:0] exp_adata;
        is_tl = (op == DtmRead) || (op == DtmWrite);
        if (op != DtmRead || tmo) exp_data = '0;
        else if (err)             exp_data = 32'hBAD0_0000;
        else                      exp_data = ref_mem[addr];
        exp_rsp = (is_tl && (err || corrupt || tmo)) ? DtmErr : DtmSuccess;
        if (op == DtmWrite && !err) ref_mem[addr] = data;
        dev_err     = err;
        dev_corrupt = corrupt;
        a_before    = a_count;
        dmi_xact(op, addr, data, hold, r, lat);
        check_eq({tag, "_data"}, 64'(r.data), 64'(exp_data));
        check_eq({tag, "_resp"}, 64'(r.resp), 64'(exp_rsp));
        if (exp_lat >= 0) check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_a_count"}, 64'(a_count - a_before), is_tl ? 64'd1 : 64'd0);
        if (is_tl) begin
            exp_addr  = BaseAddr + {23'h0, addr, 2'b00};
            exp_op    = (op == DtmWrite) ? 3'd0 : 3'd4;
            exp_adata = (op == DtmWrite) ? data : 32'h0;
            check_eq({tag, "_a_addr"}, 64'(last_a_addr), 64'(exp_addr));
            check_eq({tag, "_a_op"}, 64'(last_a_op), 64'(exp_op));
            check_eq({tag, "_a_data"}, 64'(last_a_data), 64'(exp_adata));
            check_eq({tag, "_a_mask_size"}, 64'({last_a_mask, last_a_size}), 64'({4'hF, 2'd2}));
            check_eq({tag, "_a_intg"}, 64'({last_a_cmd, last_a_dintg}),
                     64'({cmd_intg_calc(exp_op, 4'hF, exp_addr), data_intg_calc(exp_adata)}));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(dmi_req_ready), 64'd1);
        check_eq({tag, "_resp_valid"}, 64'(dmi_resp_valid), 64'd0);
        check_eq({tag, "_resp"}, 64'(dmi_resp), 64'd0);
        check_eq({tag, "_a_valid"}, 64'(tl_h2d.a_valid), 64'd0);
        check_eq({tag, "_d_ready"}, 64'(tl_h2d.d_ready), 64'd0);
        check_eq({tag, "_intg_err"}, 64'(intg_err), 64'd0);
    endtask

    initial begin
        int n;
        dmi_req = '0;
        dmi_req_valid = 1'b0;
        dmi_resp_ready = 1'b0;
        for (int i = 0; i < 128; i++) begin
            dev_mem[i] = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        dev_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed read, write, readback, NOPs, backpressure
        run_and_check("read", DtmRead, 7'h04, 32'h0, 0, 0, 0, 0, 3);
        run_and_check("write", DtmWrite, 7'h01, 32'h1234_5678, 0, 0, 0, 0, 3);
        run_and_check("readback", DtmRead, 7'h01, 32'h0, 0, 0, 0, 0, 3);
        run_and_check("nop", DtmNop, 7'h02, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        run_and_check("op3", 2'd3, 7'h03, 32'h5555_AAAA, 0, 0, 0, 0, 1);
        run_and_check("backpressure", DtmRead, 7'h01, 32'h0, 10, 0, 0, 0, 3);

        // Random traffic with random device stalls and bus errors
        dev_rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            dev_delay = $urandom_range(0, 3);
            run_and_check("rand", 2'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 2), ($urandom_range(0, 7) == 0), 0, 0, -1);
        end
        dev_rand_ready = 0;
        dev_delay = 0;

        // Bus error, then integrity corruption (sticky)
        run_and_check("buserr", DtmRead, 7'h02, 32'h0, 0, 1, 0, 0, 3);
        check_eq("buserr_intg_flag", 64'(intg_err), 64'd0);
        run_and_check("corrupt", DtmRead, 7'h03, 32'h0, 0, 0, 1, 0, 3);
        check_eq("corrupt_intg_flag", 64'(intg_err), 64'd1);
        run_and_check("after_corrupt", DtmWrite, 7'h05, 32'hCAFE_F00D, 0, 0, 0, 0, 3);
        check_eq("sticky_intg_flag", 64'(intg_err), 64'd1);

        // Beat in the last counted WaitD cycle beats the timeout
        dev_delay = TimeoutCycles - 1;
        run_and_check("edge", DtmRead, 7'h05, 32'h0, 0, 0, 0, 0, 2 + TimeoutCycles);

        // Timeout, then the late beat is drained before new requests are taken
        dev_delay = 40;
        run_and_check("timeout", DtmRead, 7'h06, 32'h0, 0, 0, 0, 1, 2 + TimeoutCycles);
        n = 0;
        while (!dmi_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_ready", 64'(dmi_req_ready), 64'd1);
        check_eq("drain_ready_cycle", 64'(cyc), 64'(d_hs_cyc + 1));
        dev_delay = 0;
        run_and_check("after_drain", DtmRead, 7'h04, 32'h0, 0, 0, 0, 0, 3);

        // Asynchronous reset while waiting on the D channel
        dev_delay = 40;
        dmi_req = '{addr: 7'h07, op: DtmRead, data: 32'h0};
        dmi_req_valid = 1'b1;
        @(negedge clk);
        dmi_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midop_d_ready", 64'(tl_h2d.d_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dev_delay = 0;
        run_and_check("post_reset", DtmRead, 7'h07, 32'h0, 0, 0, 0, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmi_tlul_bridge.md
# dmi_tlul_bridge

Converts RISC-V debug DMI requests from `dmi_jtag` into single-beat TL-UL transactions and returns the results as DMI responses. It is the downstream neighbour of the JTAG DTM in the life-cycle and debug TAP paths. It replaces a bare host adapter with a bridge that does the following:
- generates TL-UL command integrity and checks response integrity;
- maps bus errors and integrity errors onto DMI response codes;
- bounds every transaction with a timeout;
- holds the response until the DTM accepts it.

## Interface
Parameters:
- `BaseAddr`, `32'h0`: OR-ed onto the byte address `{addr, 2'b00}` to form `a_address`.
- `TimeoutCycles`, `1024`: cycles allowed in WaitD before the bridge aborts. A value of 0 disables the timeout. The counter is sized to $clog2(TimeoutCycles+1).

Ports:
- `clk_i`  in  1  clock; the block runs in a single clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `dmi_req_i`  in  `dm::dmi_req_t`  DMI request with fields addr[6:0], op, data[31:0].
- `dmi_req_valid_i`  in  1  request valid.
- `dmi_req_ready_o`  out  1  request ready.
- `dmi_resp_o`  out  `dm::dmi_resp_t`  DMI response with fields data[31:0], resp[1:0].
- `dmi_resp_valid_o`  out  1  response valid.
- `dmi_resp_ready_i`  in  1  response ready.
- `tl_o`  out  `tlul_pkg::tl_h2d_t`  TL-UL host request.
- `tl_i`  in  `tlul_pkg::tl_d2h_t`  TL-UL device response.
- `intg_err_o`  out  1  sticky flag for a response integrity error; cleared only by reset.

## Operation
The FSM has four states: Idle, ReqA, WaitD, Resp. An extra state, Drain, is used only after a timeout.

- **Idle**
  - `dmi_req_ready_o=1`.
  - On a request handshake, the bridge latches op, addr and data.
  - op = DTM_READ goes to ReqA with opcode Get.
  - op = DTM_WRITE goes to ReqA with opcode PutFullData.
  - op = DTM_NOP, or the reserved op value 3, goes directly to Resp with resp=DTM_SUCCESS and data=0.
- **ReqA**
  - `a_valid=1`, `a_size=2`, `a_mask=4'hF`, `a_source=0`.
  - `a_data` = latched data for writes, 0 for reads.
  - `a_user` is generated by `tlul_cmd_intg_gen`.
  - Fields stay stable until `a_ready`. On `a_ready`, go to WaitD.
  - The timeout does not run in ReqA, because TL-UL forbids retracting `a_valid`.
- **WaitD**
  - `d_ready=1`.
  - On `d_valid`, register the response into Resp:
    - data = `d_data` for reads, 0 for writes;
    - resp = DTM_ERR if `d_error` is set or the integrity check fails, otherwise DTM_SUCCESS.
  - An integrity failure also sets `intg_err_o`.
  - The counter increments each cycle spent in WaitD. When it reaches TimeoutCycles, go to Resp with resp=DTM_ERR and data=0, and set `drain_pending`.
- **Resp**
  - `dmi_resp_valid_o=1`; data and resp stay stable until `dmi_resp_ready_i`.
  - On the response handshake, go to Drain if `drain_pending` is set, otherwise to Idle.
- **Drain**
  - `d_ready=1` and `dmi_req_ready_o=0`.
  - The late `d_valid` beat is discarded; its integrity is still checked and still sets `intg_err_o`. Then go to Idle.
- Only one transaction is ever outstanding.
- `dmi_req_ready_o` is 1 only in Idle. This guarantees room for the response.

## Timing
- Reset values: state=Idle, `dmi_req_ready_o=1`, `dmi_resp_valid_o=0`, `dmi_resp_o='0`, `a_valid=0`, `d_ready=0`, `intg_err_o=0`, counter=0.
- Latency (request handshake in cycle N):
  - `a_valid` rises at N+1.
  - If `a_ready` is high at N+1, `d_ready` rises at N+2.
  - `d_valid` at cycle M gives `dmi_resp_valid_o` at M+1.
  - A zero-wait device gives `dmi_resp_valid_o` at N+3. A NOP gives it at N+1.
- Back-to-back requests are possible: a response handshake at cycle K allows the next request handshake at K+1.
- All outputs are driven from registers, except `tl_o.a_user`, which is combinational from registered fields.
- Boundaries:
  - The timeout fires after exactly TimeoutCycles cycles of WaitD without `d_valid`.
  - If `d_valid` arrives in the same cycle the counter expires, `d_valid` wins and the response is normal.
  - An asynchronous reset mid-transaction returns the bridge to Idle immediately. The TL device is reset in the same domain.

## Structure
- Package `dmi_tlul_pkg` contains:
  - the `dmi_tlul_state_e` enum (Idle, ReqA, WaitD, Resp, Drain);
  - the localparam DTM response codes: SUCCESS=0, ERR=2, BUSY=3 (BUSY reserved).
- Reuse `tlul_cmd_intg_gen` and `tlul_rsp_intg_chk` as sub-modules. No new sub-module is required.
- The state register uses `prim_flop` with the Idle encoding as its reset value.

## Test plan
- **Read:** DMI read addr=7'h04, BaseAddr=32'h4000_0000, device returns 32'hDEAD_BEEF one cycle after the A handshake → `a_address=32'h4000_0010`, opcode Get, resp={32'hDEAD_BEEF, SUCCESS} at N+3.
- **Write:** DMI write addr=7'h01, data=32'h1234_5678 → PutFullData with mask=4'hF; resp data=0, resp=SUCCESS.
- **Bus error:** device returns `d_error=1` → resp=ERR and `intg_err_o` stays 0. Then corrupt `d_user` integrity → resp=ERR and `intg_err_o` becomes 1 and stays 1 across later transactions.
- **Timeout:** TimeoutCycles=16, device withholds `d_valid` → resp ERR exactly 16 cycles after entering WaitD. `dmi_req_ready_o` stays 0 until the late D beat arrives at cycle +40 and is drained; then `dmi_req_ready_o` returns to 1.
- **Backpressure and NOP:** hold `dmi_resp_ready_i=0` for 10 cycles → resp stays stable and no new request is accepted. A NOP op → resp SUCCESS at N+1 with no TL traffic.
- **Reset mid-operation:** assert `rst_ni` in WaitD → all outputs return to their reset values. After release, a read completes normally.
